// File: rtl/lut_mux_tree_if.sv
// Config and evaluation handshake bundle for lut_mux_tree.
// Signal prefixes are from the LUT's point of view: i_ flows into it, o_ flows out.
interface lut_mux_tree_if #(
   parameter int K = 2
);
   logic         i_cfg_start;
   logic         i_cfg_valid;
   logic         i_cfg_bit;
   logic         o_cfg_ready;
   logic         o_cfg_done;
   logic         i_in_valid;
   logic [K-1:0] i_in_data;
   logic         o_out_valid;
   logic         o_out;

   modport master (
      output i_cfg_start, i_cfg_valid, i_cfg_bit, i_in_valid, i_in_data,
      input  o_cfg_ready, o_cfg_done, o_out_valid, o_out
   );

   modport slave (
      input  i_cfg_start, i_cfg_valid, i_cfg_bit, i_in_valid, i_in_data,
      output o_cfg_ready, o_cfg_done, o_out_valid, o_out
   );
endinterface

// File: rtl/lut_mux_tree.sv
// K-input LUT: truth table shifted in serially under a IDLE/LOAD/RUN FSM,
// looked up through a K-level tree of 2:1 muxes with a registered result.
module lut_mux_tree #(
   parameter int K = 2
) (
   input  logic          clk,
   input  logic          rst,
   lut_mux_tree_if.slave bus
);
   localparam int N = 2 ** K;
   localparam logic [K:0] LAST_IDX = (K+1)'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t       r_state;
   logic [N-1:0] r_table;
   logic [K:0]   r_cnt;
   logic         r_cfg_done;
   logic         r_out;
   logic         r_out_valid;
   logic         w_lut;

   // Level 0 muxes pairs of table entries on in_data[0]; each later level halves the width.
   for (genvar l = 0; l < K; l++) begin : g_lvl
      localparam int W = N >> (l + 1);
      logic [W-1:0] w_node;
      for (genvar j = 0; j < W; j++) begin : g_mux
         if (l == 0) begin : g_leaf
            assign w_node[j] = bus.i_in_data[0] ? r_table[2*j+1] : r_table[2*j];
         end else begin : g_inner
            assign w_node[j] = bus.i_in_data[l] ? g_lvl[l-1].w_node[2*j+1]
                                                : g_lvl[l-1].w_node[2*j];
         end
      end
   end

   assign w_lut = g_lvl[K-1].w_node[0];

   // Control FSM, table loading and registered evaluation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_table     <= {N{1'b0}};
         r_cnt       <= {(K+1){1'b0}};
         r_cfg_done  <= 1'b0;
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_cfg_start) begin
                  r_state    <= S_LOAD;
                  r_cnt      <= {(K+1){1'b0}};
                  r_cfg_done <= 1'b0;
               end
            end
            S_LOAD: begin
               // A restart discards any bit offered in the same cycle.
               if (bus.i_cfg_start) begin
                  r_cnt <= {(K+1){1'b0}};
               end else if (bus.i_cfg_valid) begin
                  r_table[r_cnt[K-1:0]] <= bus.i_cfg_bit;
                  if (r_cnt == LAST_IDX) begin
                     r_state    <= S_RUN;
                     r_cfg_done <= 1'b1;
                     r_cnt      <= {(K+1){1'b0}};
                  end else begin
                     r_cnt <= r_cnt + (K+1)'(1);
                  end
               end
            end
            S_RUN: begin
               if (bus.i_cfg_start) begin
                  r_state    <= S_LOAD;
                  r_cnt      <= {(K+1){1'b0}};
                  r_cfg_done <= 1'b0;
               end else if (bus.i_in_valid) begin
                  r_out       <= w_lut;
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= {(K+1){1'b0}};
               r_cfg_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_cfg_ready = (r_state == S_LOAD);
   assign bus.o_cfg_done  = r_cfg_done;
   assign bus.o_out       = r_out;
   assign bus.o_out_valid = r_out_valid;
endmodule

// File: tb/tb_lut_mux_tree.sv
// Directed plus randomized bench for lut_mux_tree at K=2 and K=4, checked
// against a plain truth-table array model.
module tb_lut_mux_tree;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   lut_mux_tree_if #(.K(2)) a ();
   lut_mux_tree_if #(.K(4)) b ();

   lut_mux_tree #(.K(2)) u_dut_a (.clk(clk), .rst(rst), .bus(a.slave));
   lut_mux_tree #(.K(4)) u_dut_b (.clk(clk), .rst(rst), .bus(b.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_bit(input logic v);
      a.i_cfg_valid = 1'b1;
      a.i_cfg_bit   = v;
      tick();
      a.i_cfg_valid = 1'b0;
   endtask

   task automatic a_load(input logic [3:0] t);
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      for (int i = 0; i < 4; i++) a_bit(t[i]);
   endtask

   task automatic b_load(input logic [15:0] t);
      b.i_cfg_start = 1'b1;
      tick();
      b.i_cfg_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b.i_cfg_valid = 1'b1;
         b.i_cfg_bit   = t[i];
         tick();
      end
      b.i_cfg_valid = 1'b0;
   endtask

   logic [3:0]  tbl_a;
   logic [15:0] tbl_b;
   logic        exp_a;
   logic        exp_b;

   task automatic a_eval(input logic [1:0] d, input string tag);
      a.i_in_valid = 1'b1;
      a.i_in_data  = d;
      tick();
      a.i_in_valid = 1'b0;
      exp_a = tbl_a[d];
      chk({tag, "_out"}, a.o_out, exp_a);
      chk({tag, "_vld"}, a.o_out_valid, 1'b1);
   endtask

   initial begin
      logic       v;
      logic [1:0] d2;
      logic [3:0] d4;

      rst = 1'b1;
      a.i_cfg_start = 1'b0; a.i_cfg_valid = 1'b0; a.i_cfg_bit = 1'b0;
      a.i_in_valid  = 1'b0; a.i_in_data   = 2'd0;
      b.i_cfg_start = 1'b0; b.i_cfg_valid = 1'b0; b.i_cfg_bit = 1'b0;
      b.i_in_valid  = 1'b0; b.i_in_data   = 4'd0;
      exp_a = 1'b0;
      exp_b = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      chk("rst_out",   a.o_out,       1'b0);
      chk("rst_vld",   a.o_out_valid, 1'b0);
      chk("rst_done",  a.o_cfg_done,  1'b0);
      chk("rst_ready", a.o_cfg_ready, 1'b0);
      chk("rst_b_rdy", b.o_cfg_ready, 1'b0);

      // Inputs in IDLE are ignored.
      a.i_in_valid = 1'b1; a.i_in_data = 2'd3;
      a.i_cfg_valid = 1'b1; a.i_cfg_bit = 1'b1;
      tick();
      a.i_in_valid = 1'b0; a.i_cfg_valid = 1'b0;
      chk("idle_vld",   a.o_out_valid, 1'b0);
      chk("idle_out",   a.o_out,       1'b0);
      chk("idle_ready", a.o_cfg_ready, 1'b0);

      // AND gate.
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      chk("and_ready", a.o_cfg_ready, 1'b1);
      chk("and_done0", a.o_cfg_done,  1'b0);
      a_bit(1'b0); a_bit(1'b0); a_bit(1'b0);
      chk("and_done3", a.o_cfg_done, 1'b0);
      a_bit(1'b1);
      chk("and_done",  a.o_cfg_done,  1'b1);
      chk("and_rdy0",  a.o_cfg_ready, 1'b0);
      tbl_a = 4'b1000;
      a_eval(2'd3, "and3");
      a_eval(2'd1, "and1");
      tick();
      chk("and_idle_vld", a.o_out_valid, 1'b0);
      chk("and_idle_out", a.o_out,       exp_a);

      // XOR with gaps and a restart after two bits.
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      chk("xor_done0", a.o_cfg_done, 1'b0);
      a_bit(1'b1); tick(); a_bit(1'b1);
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      chk("xor_rst_rdy", a.o_cfg_ready, 1'b1);
      a_bit(1'b0); tick(); a_bit(1'b1); a_bit(1'b1); tick();
      chk("xor_done3", a.o_cfg_done, 1'b0);
      a_bit(1'b0);
      chk("xor_done", a.o_cfg_done, 1'b1);
      tbl_a = 4'b0110;
      a_eval(2'd2, "xor2");
      a_eval(2'd3, "xor3");
      a_eval(2'd1, "xor1");

      // cfg_start beats a simultaneous accepted bit.
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      a_bit(1'b1); a_bit(1'b1);
      a.i_cfg_start = 1'b1; a.i_cfg_valid = 1'b1; a.i_cfg_bit = 1'b0;
      tick();
      a.i_cfg_start = 1'b0; a.i_cfg_valid = 1'b0;
      a_bit(1'b0); a_bit(1'b1); a_bit(1'b1);
      chk("or_done3", a.o_cfg_done, 1'b0);
      a_bit(1'b1);
      chk("or_done", a.o_cfg_done, 1'b1);
      tbl_a = 4'b1110;
      for (int i = 0; i < 4; i++) a_eval(2'(i), "or");

      // in_valid during LOAD is dropped.
      a.i_cfg_start = 1'b1;
      tick();
      a.i_cfg_start = 1'b0;
      a.i_in_valid = 1'b1; a.i_in_data = 2'd0;
      tick();
      a.i_in_valid = 1'b0;
      chk("load_vld", a.o_out_valid, 1'b0);
      chk("load_out", a.o_out,       exp_a);
      tbl_a = 4'($urandom);
      for (int i = 0; i < 4; i++) a_bit(tbl_a[i]);
      chk("rnd_done", a.o_cfg_done, 1'b1);

      // Reconfig wins over in_valid in RUN.
      a.i_cfg_start = 1'b1; a.i_in_valid = 1'b1; a.i_in_data = 2'd1;
      tick();
      a.i_cfg_start = 1'b0; a.i_in_valid = 1'b0;
      chk("cs_vld",   a.o_out_valid, 1'b0);
      chk("cs_ready", a.o_cfg_ready, 1'b1);
      chk("cs_done",  a.o_cfg_done,  1'b0);
      chk("cs_out",   a.o_out,       exp_a);
      tbl_a = 4'($urandom);
      for (int i = 0; i < 4; i++) a_bit(tbl_a[i]);

      for (int i = 0; i < 24; i++) begin
         v  = 1'($urandom_range(0, 1));
         d2 = 2'($urandom_range(0, 3));
         a.i_in_valid = v; a.i_in_data = d2;
         tick();
         if (v) exp_a = tbl_a[d2];
         chk("rnd_a_out", a.o_out,       exp_a);
         chk("rnd_a_vld", a.o_out_valid, v);
      end
      a.i_in_valid = 1'b0;

      // Mid-cycle asynchronous reset with out=1 and cfg_done=1.
      a_load(4'b1111);
      tbl_a = 4'b1111;
      a_eval(2'd0, "pre_rst");
      #3 rst = 1'b1;
      #1;
      chk("arst_out",   a.o_out,       1'b0);
      chk("arst_vld",   a.o_out_valid, 1'b0);
      chk("arst_done",  a.o_cfg_done,  1'b0);
      chk("arst_ready", a.o_cfg_ready, 1'b0);
      #1 rst = 1'b0;
      exp_a = 1'b0;
      a.i_in_valid = 1'b1; a.i_in_data = 2'd0;
      tick();
      a.i_in_valid = 1'b0;
      chk("post_rst_vld", a.o_out_valid, 1'b0);
      chk("post_rst_out", a.o_out,       1'b0);

      // K=4 random table, back-to-back sweep.
      tbl_b = 16'($urandom);
      b_load(tbl_b);
      chk("b_done", b.o_cfg_done, 1'b1);
      for (int i = 0; i < 16; i++) begin
         b.i_in_valid = 1'b1; b.i_in_data = 4'(i);
         tick();
         chk("b_sweep_out", b.o_out,       tbl_b[i]);
         chk("b_sweep_vld", b.o_out_valid, 1'b1);
      end
      exp_b = tbl_b[15];
      for (int i = 0; i < 24; i++) begin
         v  = 1'($urandom_range(0, 1));
         d4 = 4'($urandom_range(0, 15));
         b.i_in_valid = v; b.i_in_data = d4;
         tick();
         if (v) exp_b = tbl_b[d4];
         chk("rnd_b_out", b.o_out,       exp_b);
         chk("rnd_b_vld", b.o_out_valid, v);
      end
      b.i_in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
